// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// HALT_OPCODE is the all-ones word; callers slice it to their instruction width.
package cpu_fetch_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH  = 32'd2;
  localparam int unsigned DEFAULT_INSTR_WIDTH = 32'd2;

  localparam logic [63:0] HALT_OPCODE = {64{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: jump target or PC+1 (modulo 2^ADDR_WIDTH).
// wrap_o flags an increment from all-ones to zero; a jump never reports a wrap.
module pc_next
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_target_i,
  output logic [ADDR_WIDTH-1:0] pc_next_o,
  output logic                  wrap_o
);

  // Select jump or increment and flag increment wrap
  always_comb begin
    pc_next_o = pc_i + ADDR_WIDTH'(1);
    wrap_o    = 1'b0;
    if (jump_en_i) begin
      pc_next_o = jump_target_i;
      wrap_o    = 1'b0;
    end else begin
      wrap_o    = &pc_i;
    end
  end

endmodule

// File: rtl/program_counter.sv
// Fetch sequencer: owns the PC, captures memory data into a one-entry output register.
// Optional build macro PC_HALT_DECODE_EN enables halt-opcode decode (RUN -> HALT).
module program_counter
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Stall,
  input  logic                   JumpEnable,
  input  logic [ADDR_WIDTH-1:0]  JumpTarget,
  input  logic [INSTR_WIDTH-1:0] Instruction,
  input  logic                   Ready,
  output logic [ADDR_WIDTH-1:0]  InstructionAddress,
  output logic [INSTR_WIDTH-1:0] FetchedInstruction,
  output logic [ADDR_WIDTH-1:0]  FetchedAddress,
  output logic                   Valid,
  output logic                   Halted,
  output logic                   End
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  fa_q, fa_d;
  logic [INSTR_WIDTH-1:0] fi_q, fi_d;
  logic                   valid_q, valid_d;
  logic                   end_q, end_d;
  logic [ADDR_WIDTH-1:0]  pc_next_s;
  logic                   wrap_s;
  logic                   advance_s;
  logic                   term_s;

  pc_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_next (
    .pc_i          (pc_q),
    .jump_en_i     (JumpEnable),
    .jump_target_i (JumpTarget),
    .pc_next_o     (pc_next_s),
    .wrap_o        (wrap_s)
  );

  assign advance_s = !Stall && (state_q == ST_RUN) && (!valid_q || Ready);

`ifdef PC_HALT_DECODE_EN
  logic unused_wrap_s;
  assign unused_wrap_s = wrap_s;
  assign term_s        = (Instruction == HALT_OPCODE[INSTR_WIDTH-1:0]);
  assign Halted        = (state_q == ST_HALT);
`else
  assign term_s        = wrap_s;
  assign Halted        = 1'b0;
`endif

  // Next-state, PC and output-register update; Stall holds everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fi_d    = fi_q;
    fa_d    = fa_q;
    valid_d = valid_q;
    end_d   = 1'b0;
    if (!Stall) begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_d = ST_RUN;
            pc_d    = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (advance_s) begin
            fi_d    = Instruction;
            fa_d    = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_next_s;
            end_d   = term_s;
`ifdef PC_HALT_DECODE_EN
            if (term_s) begin
              state_d = ST_HALT;
            end else begin
              state_d = ST_RUN;
            end
`endif
          end else if (valid_q && Ready) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        ST_HALT: begin
          // Restart drops any word still waiting for the decoder
          if (Start) begin
            state_d = ST_RUN;
            pc_d    = '0;
            valid_d = 1'b0;
          end else if (Ready) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      end_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      fi_q    <= '0;
      fa_q    <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fi_q    <= fi_d;
      fa_q    <= fa_d;
      valid_q <= valid_d;
      end_q   <= end_d;
    end
  end

  assign InstructionAddress = pc_q;
  assign FetchedInstruction = fi_q;
  assign FetchedAddress     = fa_q;
  assign Valid              = valid_q;
  assign End                = end_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed vector table, hand sequences, then random
// stimulus against a behavioural model. Follows PC_HALT_DECODE_EN if defined.
module tb_program_counter;

  localparam int AW = 2;
  localparam int IW = 2;
`ifdef PC_HALT_DECODE_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset, Start, Stall, JumpEnable, Ready;
  logic [AW-1:0] JumpTarget, InstructionAddress, FetchedAddress;
  logic [IW-1:0] Instruction, FetchedInstruction;
  logic          Valid, Halted, End;
  logic [IW-1:0] mem [4];

  int vectors = 0;
  int miscompares = 0;

  // model state: 0 idle, 1 run, 2 halt
  int m_state, m_pc, m_fi, m_fa;
  bit m_valid, m_end;

  typedef struct {
    string name;
    bit    rst, start, stall, ready, jen;
    int    jt;
    int    pc;
    bit    valid;
    int    fi, fa;
    bit    halted, endp;
  } vec_t;
  vec_t tbl[$];

  program_counter #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .Start              (Start),
    .Stall              (Stall),
    .JumpEnable         (JumpEnable),
    .JumpTarget         (JumpTarget),
    .Instruction        (Instruction),
    .Ready              (Ready),
    .InstructionAddress (InstructionAddress),
    .FetchedInstruction (FetchedInstruction),
    .FetchedAddress     (FetchedAddress),
    .Valid              (Valid),
    .Halted             (Halted),
    .End                (End)
  );

  always #5 Clock = ~Clock;
  assign Instruction = mem[InstructionAddress];

  function automatic void add(string name, bit rst, bit start, bit stall, bit ready, bit jen,
                              int jt, int pc, bit valid, int fi, int fa, bit halted, bit endp);
    vec_t v;
    v.name = name; v.rst = rst; v.start = start; v.stall = stall; v.ready = ready;
    v.jen = jen; v.jt = jt; v.pc = pc; v.valid = valid; v.fi = fi; v.fa = fa;
    v.halted = halted; v.endp = endp;
    tbl.push_back(v);
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit stl, input bit rdy,
                            input bit jen, input int jt);
    m_end = 1'b0;
    if (rst) begin
      m_state = 0; m_pc = 0; m_fi = 0; m_fa = 0; m_valid = 1'b0;
    end else if (!stl) begin
      if (m_state == 0) begin
        if (st) begin m_state = 1; m_pc = 0; end
      end else if (m_state == 1) begin
        if (!m_valid || rdy) begin
          m_fi = int'(mem[m_pc]);
          m_fa = m_pc;
          m_valid = 1'b1;
          if (HALT_EN) begin
            if (m_fi == (1 << IW) - 1) begin m_end = 1'b1; m_state = 2; end
          end else begin
            m_end = !jen && (m_pc == (1 << AW) - 1);
          end
          m_pc = jen ? jt : (m_pc + 1) % (1 << AW);
        end
      end else begin
        if (st) begin m_state = 1; m_pc = 0; m_valid = 1'b0; end
        else if (rdy) m_valid = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit st, input bit stl, input bit rdy,
                       input bit jen, input int jt);
    Reset = rst; Start = st; Stall = stl; Ready = rdy; JumpEnable = jen;
    JumpTarget = AW'(jt);
    @(posedge Clock);
    model_step(rst, st, stl, rdy, jen, jt);
    #1;
  endtask

  task automatic check(input string name, input int pc, input bit valid, input int fi,
                       input int fa, input bit halted, input bit endp);
    vectors++;
    if (InstructionAddress !== AW'(pc) || Valid !== valid || FetchedInstruction !== IW'(fi) ||
        FetchedAddress !== AW'(fa) || Halted !== halted || End !== endp) begin
      miscompares++;
      $display("FAIL %s: got pc=%0d v=%0b fi=%0d fa=%0d h=%0b e=%0b, want pc=%0d v=%0b fi=%0d fa=%0d h=%0b e=%0b",
               name, InstructionAddress, Valid, FetchedInstruction, FetchedAddress, Halted, End,
               pc, valid, fi, fa, halted, endp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = IW'(i);
    Reset = 1'b1; Start = 1'b0; Stall = 1'b0; Ready = 1'b0; JumpEnable = 1'b0;
    JumpTarget = '0;

    // name, rst start stall ready jen jt, pc valid fi fa halted end
    add("reset",           1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add("start",           0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    add("fetch0",          0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    add("jump1to0",        0, 0, 0, 1, 1, 0,  0, 1, 1, 1, 0, 0);
    add("after_jump",      0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    add("fetch1",          0, 0, 0, 1, 0, 0,  2, 1, 1, 1, 0, 0);
    add("bp1",             0, 0, 0, 0, 0, 0,  2, 1, 1, 1, 0, 0);
    add("bp2",             0, 0, 0, 0, 0, 0,  2, 1, 1, 1, 0, 0);
    add("bp3",             0, 0, 0, 0, 0, 0,  2, 1, 1, 1, 0, 0);
    add("bp_jump_ignored", 0, 0, 0, 0, 1, 3,  2, 1, 1, 1, 0, 0);
    add("resume2",         0, 0, 0, 1, 0, 0,  3, 1, 2, 2, 0, 0);
    add("stall_ready",     0, 0, 1, 1, 0, 0,  3, 1, 2, 2, 0, 0);
    add("stall_all",       0, 1, 1, 1, 1, 0,  3, 1, 2, 2, 0, 0);
`ifdef PC_HALT_DECODE_EN
    add("halt_capture",    0, 0, 0, 1, 0, 0,  0, 1, 3, 3, 1, 1);
    add("halt_hold",       0, 0, 0, 0, 0, 0,  0, 1, 3, 3, 1, 0);
    add("halt_accept",     0, 0, 0, 1, 0, 0,  0, 0, 3, 3, 1, 0);
    add("halt_idle",       0, 0, 0, 1, 0, 0,  0, 0, 3, 3, 1, 0);
    add("restart",         0, 1, 0, 1, 0, 0,  0, 0, 3, 3, 0, 0);
    add("restart_fetch",   0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0);
`else
    add("jump3_no_end",    0, 0, 0, 1, 1, 0,  0, 1, 3, 3, 0, 0);
    add("run0",            0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    add("run1",            0, 0, 0, 1, 0, 0,  2, 1, 1, 1, 0, 0);
    add("run2",            0, 0, 0, 1, 0, 0,  3, 1, 2, 2, 0, 0);
    add("wrap_end",        0, 0, 0, 1, 0, 0,  0, 1, 3, 3, 0, 1);
    add("after_wrap",      0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0);
`endif

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].start, tbl[k].stall, tbl[k].ready, tbl[k].jen, tbl[k].jt);
      check(tbl[k].name, tbl[k].pc, tbl[k].valid, tbl[k].fi, tbl[k].fa, tbl[k].halted, tbl[k].endp);
    end

    // Reset while a word is held under backpressure drops it and returns to IDLE
    drive(0, 0, 0, 0, 0, 0); check("pre_reset_hold", 1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); check("reset_midrun",   0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0); check("idle_no_start",  0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0); check("start_again",    0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      check($sformatf("seq%0d", i), (i + 1) % 4, 1, i, i, HALT_EN && (i == 3), i == 3);
    end

    // Random stimulus against the behavioural model
    drive(1, 0, 0, 0, 0, 0);
    check("rand_reset", m_pc, m_valid, m_fi, m_fa, m_state == 2, m_end);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)));
      check($sformatf("rand%0d", i), m_pc, m_valid, m_fi, m_fa, m_state == 2, m_end);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
